// File: rtl/branch_redirect_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_redirect_ctrl_pkg                                        |
// | Brief    : Shared pipeline constants and branch-redirect FSM state type.   |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package branch_redirect_ctrl_pkg;

  localparam int unsigned c_xlen        = 32;
  localparam int unsigned c_flush_cnt_w = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } redirect_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_counter                                                     |
// | Brief    : Saturating up-counter with asynchronous active-low reset.       |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Holds at all-ones rather than wrapping so software never sees a small count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_redirect_ctrl                                            |
// | Brief    : EX-stage branch resolution, registered PC redirect, flush and   |
// |            load-use stall arbitration, taken strobe and statistics.        |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = c_xlen,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_cond,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             load_use_hazard,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             branch,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [c_flush_cnt_w-1:0] c_flush_init = c_flush_cnt_w'(FLUSH_CYCLES - 1);

  redirect_state_t          r_state;
  redirect_state_t          w_state_nxt;
  logic [c_flush_cnt_w-1:0] r_cnt;
  logic [c_flush_cnt_w-1:0] w_cnt_nxt;
  logic                     r_first;
  logic                     w_first_nxt;
  logic                     w_load;
  logic                     w_taken;
  logic [XLEN-1:0]          r_redirect_pc;
  logic                     r_misalign;

  // A jump wins over a branch when both decode bits are set.
  assign w_taken = ex_valid & (ex_is_jump | (ex_is_branch & ex_cond));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_taken) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = c_flush_init;
          w_first_nxt = 1'b1;
          w_load      = 1'b1;
        end
      end
      ST_FLUSH: begin
        // EX holds wrong-path instructions here, so its inputs are ignored.
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_flush_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redirect_pc <= '0;
      r_misalign    <= 1'b0;
    end else if (w_load) begin
      r_redirect_pc <= {ex_target[XLEN-1:2], 2'b00};
      if (ex_target[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_load),
    .count (taken_count)
  );

  assign pc_redirect  = r_first;
  assign branch       = r_first;
  assign flush_ifid   = (r_state == ST_FLUSH);
  assign flush_idex   = (r_state == ST_FLUSH);
  assign redirect_pc  = r_redirect_pc;
  assign misalign_err = r_misalign;

  // The hazard instruction is about to be squashed, so flushing beats stalling.
  assign stall_if = (r_state == ST_IDLE) & load_use_hazard & ~w_taken;
  assign stall_id = (r_state == ST_IDLE) & load_use_hazard & ~w_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_redirect_ctrl                                         |
// | Brief    : Directed self-checking bench for branch_redirect_ctrl.          |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_cond;
  logic [XLEN-1:0]  ex_target;
  logic             load_use_hazard;
  logic             pc_redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_ifid;
  logic             flush_idex;
  logic             stall_if;
  logic             stall_id;
  logic             branch;
  logic             misalign_err;
  logic [CNT_W-1:0] taken_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  branch_redirect_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .ex_valid        (ex_valid),
    .ex_is_branch    (ex_is_branch),
    .ex_is_jump      (ex_is_jump),
    .ex_cond         (ex_cond),
    .ex_target       (ex_target),
    .load_use_hazard (load_use_hazard),
    .pc_redirect     (pc_redirect),
    .redirect_pc     (redirect_pc),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .branch          (branch),
    .misalign_err    (misalign_err),
    .taken_count     (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic pcr, input logic br,
                         input logic fl, input logic st, input logic [31:0] rpc,
                         input logic mis, input int cnt);
    chk($sformatf("%s.pc_redirect", tag), {31'd0, pc_redirect}, {31'd0, pcr});
    chk($sformatf("%s.branch", tag), {31'd0, branch}, {31'd0, br});
    chk($sformatf("%s.flush_ifid", tag), {31'd0, flush_ifid}, {31'd0, fl});
    chk($sformatf("%s.flush_idex", tag), {31'd0, flush_idex}, {31'd0, fl});
    chk($sformatf("%s.stall_if", tag), {31'd0, stall_if}, {31'd0, st});
    chk($sformatf("%s.stall_id", tag), {31'd0, stall_id}, {31'd0, st});
    chk($sformatf("%s.redirect_pc", tag), redirect_pc, rpc);
    chk($sformatf("%s.misalign_err", tag), {31'd0, misalign_err}, {31'd0, mis});
    chk($sformatf("%s.taken_count", tag), {28'd0, taken_count}, cnt);
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic c,
                       input logic [31:0] t, input logic luh);
    ex_valid        = v;
    ex_is_branch    = b;
    ex_is_jump      = j;
    ex_cond         = c;
    ex_target       = t;
    load_use_hazard = luh;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 0, 32'h0, 0, 0);
    end

    // Taken branch to 0x100
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    step();
    idle_in();
    bump();
    chk_all("tk_n1", 1, 1, 1, 0, 32'h100, 0, exp_cnt);
    step();
    chk_all("tk_n2", 0, 0, 1, 0, 32'h100, 0, exp_cnt);
    step();
    chk_all("tk_n3", 0, 0, 0, 0, 32'h100, 0, exp_cnt);

    // Not-taken branch, then a lone load-use hazard
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 1'b0);
    step();
    chk_all("nt", 0, 0, 0, 0, 32'h100, 0, exp_cnt);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk_all("luh_only", 0, 0, 0, 1, 32'h100, 0, exp_cnt);
    step();
    idle_in();

    // Taken with load-use in the same cycle, then a jump during FLUSH
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0180, 1'b1);
    #1;
    chk_all("tkluh_pre", 0, 0, 0, 0, 32'h100, 0, exp_cnt);
    step();
    bump();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_02C0, 1'b1);
    #1;
    chk_all("tkluh_f1", 1, 1, 1, 0, 32'h180, 0, exp_cnt);
    step();
    chk_all("tkluh_f2", 0, 0, 1, 0, 32'h180, 0, exp_cnt);
    step();
    idle_in();
    #1;
    chk_all("tkluh_end", 0, 0, 0, 0, 32'h180, 0, exp_cnt);

    // Misaligned jump, then 5 back-to-back aligned branches
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0206, 1'b0);
    step();
    idle_in();
    bump();
    chk_all("mis_f1", 1, 1, 1, 0, 32'h204, 1, exp_cnt);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400 + 32'(i * 16), 1'b0);
      step();
      idle_in();
      bump();
      chk_all($sformatf("b2b%0d_f1", i), 1, 1, 1, 0, 32'h0000_0400 + 32'(i * 16), 1, exp_cnt);
      step();
      chk_all($sformatf("b2b%0d_f2", i), 0, 0, 1, 0, 32'h0000_0400 + 32'(i * 16), 1, exp_cnt);
      step();
      chk_all($sformatf("b2b%0d_id", i), 0, 0, 0, 0, 32'h0000_0400 + 32'(i * 16), 1, exp_cnt);
    end

    // Asynchronous reset in the second FLUSH cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0140, 1'b0);
    step();
    idle_in();
    bump();
    step();
    chk_all("rst_f2", 0, 0, 1, 0, 32'h140, 1, exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk_all("rst_async", 0, 0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
    step();
    idle_in();
    bump();
    chk_all("post_rst_f1", 1, 1, 1, 0, 32'h300, 0, exp_cnt);
    step();
    step();
    chk_all("post_rst_id", 0, 0, 0, 0, 32'h300, 0, exp_cnt);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000 + 32'(i * 4), 1'b0);
      step();
      idle_in();
      bump();
      chk($sformatf("sat%0d.taken_count", i), {28'd0, taken_count}, exp_cnt);
      step();
      step();
    end
    chk("sat_final.taken_count", {28'd0, taken_count}, 32'd15);
    chk_all("sat_final", 0, 0, 0, 0, 32'h0000_1040, 0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
